// File: rtl/surf_cmd_pkg.sv
// SURF command word format: field layout, run-command encoding and parity helper.
// Shared by the command builder and anything decoding the word downstream.
package surf_cmd_pkg;

   localparam int unsigned CMD_W       = 32;
   localparam int unsigned TRIG_TIME_W = 15;
   localparam int unsigned MSG_W       = 8;
   localparam int unsigned RUNCMD_W    = 2;
   localparam int unsigned PHASE_W     = 3;

   localparam int unsigned TRIG_TIME_LSB  = 0;
   localparam int unsigned TRIG_VALID_BIT = 15;
   localparam int unsigned MSG_LSB        = 16;
   localparam int unsigned MSG_VALID_BIT  = 24;
   localparam int unsigned RUNCMD_LSB     = 25;
   localparam int unsigned PARITY_BIT     = 31;

   // Phase at whose clock edge the word is built; the CIN side samples at the next phase.
   localparam logic [PHASE_W-1:0] BUILD_PHASE = 3'd6;

   // Link-training pattern, kept next to the word format it must stay distinct from.
   localparam logic [CMD_W-1:0] CMD_TRAIN = 32'h5A5A_0F0F;

   typedef enum logic [RUNCMD_W-1:0] {
      RUNCMD_NOP   = 2'd0,
      RUNCMD_RESET = 2'd1,
      RUNCMD_START = 2'd2,
      RUNCMD_STOP  = 2'd3
   } runcmd_e;

   typedef struct packed {
      logic                   parity;
      logic [3:0]             rsvd;
      runcmd_e                runcmd;
      logic                   msg_valid;
      logic [MSG_W-1:0]       msg;
      logic                   trig_valid;
      logic [TRIG_TIME_W-1:0] trig_time;
   } cmd_word_t;

   // Assemble a word; the top bit makes the total count of ones even.
   function automatic logic [CMD_W-1:0] build_cmd(
      input logic                   trig_v,
      input logic [TRIG_TIME_W-1:0] trig_time,
      input logic                   msg_v,
      input logic [MSG_W-1:0]       msg,
      input runcmd_e                runcmd
   );
      cmd_word_t        w;
      logic [CMD_W-1:0] raw;
      w            = '0;
      w.trig_valid = trig_v;
      w.trig_time  = trig_v ? trig_time : '0;
      w.msg_valid  = msg_v;
      w.msg        = msg_v ? msg : '0;
      w.runcmd     = runcmd;
      raw          = w;
      raw[PARITY_BIT] = ^raw[PARITY_BIT-1:0];
      return raw;
   endfunction

endpackage

// File: rtl/surf_cmd_trig_fifo.sv
// Synchronous trigger-time FIFO with first-word-fall-through head.
// A push while full is accepted only when a pop happens on the same edge.
module surf_cmd_trig_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 15
) (
   input  logic             sysclk_i,
   input  logic             rst_i,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign head    = mem[rd_ptr];

   always_ff @(posedge sysclk_i) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge sysclk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/surf_command_builder.sv
// Builds one SURF command word per 8-clock slot from triggers, run commands and
// message bytes; phase tracking mirrors the CIN interface on the shared sync.
module surf_command_builder
   import surf_cmd_pkg::*;
#(
   parameter int unsigned TRIG_FIFO_DEPTH = 4
) (
   input  logic                   sysclk_i,
   input  logic                   rst_i,
   input  logic                   sync_i,
   input  logic                   enable_i,
   input  logic                   trig_valid_i,
   input  logic [TRIG_TIME_W-1:0] trig_time_i,
   output logic                   trig_overflow_o,
   input  logic                   runcmd_valid_i,
   input  logic [RUNCMD_W-1:0]    runcmd_i,
   output logic                   runcmd_lost_o,
   input  logic [MSG_W-1:0]       msg_tdata_i,
   input  logic                   msg_tvalid_i,
   output logic                   msg_tready_o,
   input  logic                   clear_i,
   output logic [CMD_W-1:0]       command_o
);

   logic [PHASE_W-1:0]     phase_q, phase_d;
   logic [CMD_W-1:0]       cmd_q, cmd_d;
   runcmd_e                pend_q, pend_d;
   logic                   ovf_q, ovf_d;
   logic                   lost_q, lost_d;

   logic                   slot_build;
   logic                   slot_take;
   logic                   msg_xfer;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [TRIG_TIME_W-1:0] fifo_head;
   logic                   runcmd_strobe;

   surf_cmd_trig_fifo #(
      .DEPTH (TRIG_FIFO_DEPTH),
      .WIDTH (TRIG_TIME_W)
   ) u_trig_fifo (
      .sysclk_i (sysclk_i),
      .rst_i    (rst_i),
      .push     (trig_valid_i),
      .din      (trig_time_i),
      .pop      (fifo_pop),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Next-state: phase, word build, pending run command and sticky flags.
   always_comb begin
      phase_d       = sync_i ? PHASE_W'(1) : phase_q + PHASE_W'(1);
      cmd_d         = cmd_q;
      pend_d        = pend_q;
      ovf_d         = ovf_q;
      lost_d        = lost_q;
      slot_build    = (phase_q == BUILD_PHASE);
      slot_take     = slot_build & enable_i;
      msg_xfer      = slot_take & msg_tvalid_i;
      fifo_pop      = slot_take & ~fifo_empty;
      runcmd_strobe = runcmd_valid_i & (runcmd_e'(runcmd_i) != RUNCMD_NOP);

      if (slot_build) begin
         cmd_d = slot_take ? build_cmd(fifo_pop, fifo_head, msg_xfer, msg_tdata_i, pend_q)
                           : '0;
      end

      // A strobe landing on the consuming edge simply becomes the next pending command.
      if (slot_take) pend_d = RUNCMD_NOP;
      if (runcmd_strobe) begin
         if ((pend_q != RUNCMD_NOP) && !slot_take) lost_d = 1'b1;
         pend_d = runcmd_e'(runcmd_i);
      end
      if (clear_i && !(runcmd_strobe && (pend_q != RUNCMD_NOP) && !slot_take)) lost_d = 1'b0;

      if (clear_i) ovf_d = 1'b0;
      if (trig_valid_i && fifo_full && !fifo_pop) ovf_d = 1'b1;
   end

   always_ff @(posedge sysclk_i) begin
      if (rst_i) begin
         phase_q <= '0;
         cmd_q   <= '0;
         pend_q  <= RUNCMD_NOP;
         ovf_q   <= 1'b0;
         lost_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cmd_q   <= cmd_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         lost_q  <= lost_d;
      end
   end

   // Ready is the accept window itself, so it tracks enable_i within the build cycle.
   assign msg_tready_o    = slot_take;
   assign command_o       = cmd_q;
   assign trig_overflow_o = ovf_q;
   assign runcmd_lost_o   = lost_q;

endmodule

// File: tb/tb_surf_command_builder.sv
// Directed bench for surf_command_builder; tracks slot phase alongside the DUT
// and checks each built word against hand-computed values.
module tb_surf_command_builder;

   logic        sysclk_i = 1'b0;
   logic        rst_i;
   logic        sync_i;
   logic        enable_i;
   logic        trig_valid_i;
   logic [14:0] trig_time_i;
   logic        trig_overflow_o;
   logic        runcmd_valid_i;
   logic [1:0]  runcmd_i;
   logic        runcmd_lost_o;
   logic [7:0]  msg_tdata_i;
   logic        msg_tvalid_i;
   logic        msg_tready_o;
   logic        clear_i;
   logic [31:0] command_o;

   int          total = 0;
   int          bad   = 0;
   logic [2:0]  bph   = 3'd0;
   logic        sync_req = 1'b0;

   always #5 sysclk_i = ~sysclk_i;

   surf_command_builder #(.TRIG_FIFO_DEPTH(4)) dut (
      .sysclk_i        (sysclk_i),
      .rst_i           (rst_i),
      .sync_i          (sync_i),
      .enable_i        (enable_i),
      .trig_valid_i    (trig_valid_i),
      .trig_time_i     (trig_time_i),
      .trig_overflow_o (trig_overflow_o),
      .runcmd_valid_i  (runcmd_valid_i),
      .runcmd_i        (runcmd_i),
      .runcmd_lost_o   (runcmd_lost_o),
      .msg_tdata_i     (msg_tdata_i),
      .msg_tvalid_i    (msg_tvalid_i),
      .msg_tready_o    (msg_tready_o),
      .clear_i         (clear_i),
      .command_o       (command_o)
   );

   // One clock: free-running sync at phase 0, phase model update, settle 1ns past the edge.
   task automatic step();
      sync_i = sync_req | ((bph == 3'd0) & ~rst_i);
      @(posedge sysclk_i);
      if (rst_i)       bph = 3'd0;
      else if (sync_i) bph = 3'd1;
      else             bph = bph + 3'd1;
      #1;
   endtask

   task automatic go(input logic [2:0] p);
      for (int i = 0; i < 16 && bph != p; i++) step();
      if (bph != p) begin
         $display("FAIL phase_wait: at=%0d want=%0d", bph, p);
         bad++;
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; sync_i = 1'b0; enable_i = 1'b1; trig_valid_i = 1'b0; trig_time_i = '0;
      runcmd_valid_i = 1'b0; runcmd_i = '0; msg_tdata_i = '0; msg_tvalid_i = 1'b0; clear_i = 1'b0;
      repeat (3) step();
      rst_i = 1'b0;
      total++; if (command_o !== 32'h0) begin $display("FAIL reset_cmd: got=%h exp=%h", command_o, 32'h0); bad++; end
      total++; if (trig_overflow_o !== 1'b0) begin $display("FAIL reset_ovf: got=%b exp=0", trig_overflow_o); bad++; end
      total++; if (runcmd_lost_o !== 1'b0) begin $display("FAIL reset_lost: got=%b exp=0", runcmd_lost_o); bad++; end
      total++; if (msg_tready_o !== 1'b0) begin $display("FAIL reset_tready: got=%b exp=0", msg_tready_o); bad++; end
   endtask

   task automatic test_idle();
      for (int s = 0; s < 3; s++) begin
         go(3'd7);
         total++; if (command_o !== 32'h0) begin $display("FAIL idle_word%0d: got=%h exp=%h", s, command_o, 32'h0); bad++; end
         step();
      end
   endtask

   task automatic test_single_trig();
      go(3'd2);
      trig_valid_i = 1'b1; trig_time_i = 15'h1234;
      step();
      trig_valid_i = 1'b0;
      go(3'd7);
      total++; if (command_o !== 32'h0000_9234) begin $display("FAIL trig_word: got=%h exp=%h", command_o, 32'h0000_9234); bad++; end
      step(); go(3'd7);
      total++; if (command_o !== 32'h0) begin $display("FAIL trig_drained: got=%h exp=%h", command_o, 32'h0); bad++; end
   endtask

   task automatic test_overflow();
      logic [31:0] exp [4];
      exp[0] = 32'h0000_8002; exp[1] = 32'h8000_8003; exp[2] = 32'h0000_8004; exp[3] = 32'h0;
      go(3'd1);
      for (int k = 1; k <= 5; k++) begin
         trig_valid_i = 1'b1; trig_time_i = 15'(k);
         step();
      end
      trig_valid_i = 1'b0;
      total++; if (trig_overflow_o !== 1'b1) begin $display("FAIL ovf_set: got=%b exp=1", trig_overflow_o); bad++; end
      step();
      total++; if (command_o !== 32'h0000_8001) begin $display("FAIL ovf_word0: got=%h exp=%h", command_o, 32'h0000_8001); bad++; end
      for (int s = 0; s < 4; s++) begin
         step(); go(3'd7);
         total++; if (command_o !== exp[s]) begin $display("FAIL ovf_word%0d: got=%h exp=%h", s + 1, command_o, exp[s]); bad++; end
      end
      total++; if (trig_overflow_o !== 1'b1) begin $display("FAIL ovf_sticky: got=%b exp=1", trig_overflow_o); bad++; end
      clear_i = 1'b1; step(); clear_i = 1'b0;
      total++; if (trig_overflow_o !== 1'b0) begin $display("FAIL ovf_clear: got=%b exp=0", trig_overflow_o); bad++; end
   endtask

   task automatic test_runcmd();
      go(3'd1);
      runcmd_valid_i = 1'b1; runcmd_i = 2'd2; step();
      runcmd_i = 2'd3; step();
      runcmd_valid_i = 1'b0;
      total++; if (runcmd_lost_o !== 1'b1) begin $display("FAIL lost_set: got=%b exp=1", runcmd_lost_o); bad++; end
      go(3'd7);
      total++; if (command_o !== 32'h0600_0000) begin $display("FAIL runcmd_stop: got=%h exp=%h", command_o, 32'h0600_0000); bad++; end
      clear_i = 1'b1; step(); clear_i = 1'b0;
      total++; if (runcmd_lost_o !== 1'b0) begin $display("FAIL lost_clear: got=%b exp=0", runcmd_lost_o); bad++; end
      go(3'd6);
      runcmd_valid_i = 1'b1; runcmd_i = 2'd1; step();
      runcmd_valid_i = 1'b0;
      total++; if (command_o !== 32'h0) begin $display("FAIL runcmd_p6_word: got=%h exp=%h", command_o, 32'h0); bad++; end
      total++; if (runcmd_lost_o !== 1'b0) begin $display("FAIL runcmd_p6_lost: got=%b exp=0", runcmd_lost_o); bad++; end
      go(3'd2);
      runcmd_valid_i = 1'b1; runcmd_i = 2'd0; step();
      runcmd_valid_i = 1'b0;
      go(3'd7);
      total++; if (command_o !== 32'h8200_0000) begin $display("FAIL runcmd_held: got=%h exp=%h", command_o, 32'h8200_0000); bad++; end
      total++; if (runcmd_lost_o !== 1'b0) begin $display("FAIL runcmd_nop_lost: got=%b exp=0", runcmd_lost_o); bad++; end
   endtask

   task automatic test_message();
      go(3'd1);
      msg_tdata_i = 8'hA5; msg_tvalid_i = 1'b1;
      go(3'd3);
      total++; if (msg_tready_o !== 1'b0) begin $display("FAIL tready_p3: got=%b exp=0", msg_tready_o); bad++; end
      go(3'd6);
      total++; if (msg_tready_o !== 1'b1) begin $display("FAIL tready_p6: got=%b exp=1", msg_tready_o); bad++; end
      step();
      total++; if (command_o !== 32'h81A5_0000) begin $display("FAIL msg_word: got=%h exp=%h", command_o, 32'h81A5_0000); bad++; end
      total++; if (msg_tready_o !== 1'b0) begin $display("FAIL tready_p7: got=%b exp=0", msg_tready_o); bad++; end
      msg_tvalid_i = 1'b0;
   endtask

   task automatic test_enable();
      go(3'd1);
      enable_i = 1'b0; trig_valid_i = 1'b1; trig_time_i = 15'h0007;
      step();
      trig_valid_i = 1'b0;
      go(3'd6);
      total++; if (msg_tready_o !== 1'b0) begin $display("FAIL dis_tready: got=%b exp=0", msg_tready_o); bad++; end
      step();
      total++; if (command_o !== 32'h0) begin $display("FAIL dis_word: got=%h exp=%h", command_o, 32'h0); bad++; end
      enable_i = 1'b1;
      step(); go(3'd7);
      total++; if (command_o !== 32'h0000_8007) begin $display("FAIL reen_word: got=%h exp=%h", command_o, 32'h0000_8007); bad++; end
   endtask

   task automatic test_sync_mid();
      go(3'd1);
      trig_valid_i = 1'b1; trig_time_i = 15'h0100; step(); trig_valid_i = 1'b0;
      go(3'd3);
      sync_req = 1'b1; step(); sync_req = 1'b0;
      total++; if (command_o !== 32'h0000_8007) begin $display("FAIL sync_hold: got=%h exp=%h", command_o, 32'h0000_8007); bad++; end
      go(3'd6);
      total++; if (msg_tready_o !== 1'b1) begin $display("FAIL sync_align: got=%b exp=1", msg_tready_o); bad++; end
      step();
      total++; if (command_o !== 32'h0000_8100) begin $display("FAIL sync_word: got=%h exp=%h", command_o, 32'h0000_8100); bad++; end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] exp [5];
      exp[0] = 32'h8000_8012; exp[1] = 32'h0000_8013; exp[2] = 32'h8000_8014;
      exp[3] = 32'h0000_8015; exp[4] = 32'h0;
      go(3'd1);
      for (int k = 0; k < 4; k++) begin
         trig_valid_i = 1'b1; trig_time_i = 15'(16'h11 + k); step();
      end
      trig_valid_i = 1'b0;
      go(3'd6);
      trig_valid_i = 1'b1; trig_time_i = 15'h0015; step(); trig_valid_i = 1'b0;
      total++; if (trig_overflow_o !== 1'b0) begin $display("FAIL pushpop_ovf: got=%b exp=0", trig_overflow_o); bad++; end
      total++; if (command_o !== 32'h8000_8011) begin $display("FAIL pushpop_word0: got=%h exp=%h", command_o, 32'h8000_8011); bad++; end
      for (int s = 0; s < 5; s++) begin
         step(); go(3'd7);
         total++; if (command_o !== exp[s]) begin $display("FAIL pushpop_word%0d: got=%h exp=%h", s + 1, command_o, exp[s]); bad++; end
      end
   endtask

   task automatic test_clear_race_and_reset();
      go(3'd1);
      for (int k = 0; k < 4; k++) begin
         trig_valid_i = 1'b1; trig_time_i = 15'(16'h21 + k); step();
      end
      trig_valid_i = 1'b1; trig_time_i = 15'h0025; clear_i = 1'b1;
      runcmd_valid_i = 1'b1; runcmd_i = 2'd2;
      step();
      trig_valid_i = 1'b0; clear_i = 1'b0; runcmd_valid_i = 1'b0;
      total++; if (trig_overflow_o !== 1'b1) begin $display("FAIL clear_race: got=%b exp=1", trig_overflow_o); bad++; end
      rst_i = 1'b1; step(); rst_i = 1'b0;
      total++; if (trig_overflow_o !== 1'b0) begin $display("FAIL midrst_ovf: got=%b exp=0", trig_overflow_o); bad++; end
      total++; if (msg_tready_o !== 1'b0) begin $display("FAIL midrst_tready: got=%b exp=0", msg_tready_o); bad++; end
      go(3'd7);
      total++; if (command_o !== 32'h0) begin $display("FAIL midrst_word: got=%h exp=%h", command_o, 32'h0); bad++; end
      step(); go(3'd7);
      total++; if (command_o !== 32'h0) begin $display("FAIL midrst_word2: got=%h exp=%h", command_o, 32'h0); bad++; end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_trig();
      test_overflow();
      test_runcmd();
      test_message();
      test_enable();
      test_sync_mid();
      test_full_push_pop();
      test_clear_race_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
